// File: rtl/dispara_tiro_pkg.sv
// Shared definitions for the shot-spawn controller and the shot-movement FSM:
// state encodings and shot direction opcodes.
package dispara_tiro_pkg;

    typedef enum logic [4:0] {
        INICIAL    = 5'd0,
        ESPERA     = 5'd1,
        LE_SLOT    = 5'd2,
        AGUARDA    = 5'd3,
        TESTA      = 5'd4,
        ESCREVE    = 5'd5,
        PROXIMO    = 5'd6,
        CONCLUIDO  = 5'd7,
        SEM_ESPACO = 5'd8,
        COOLDOWN   = 5'd9
    } estado_t;

    localparam logic [1:0] OP_CIMA     = 2'b00;
    localparam logic [1:0] OP_DIREITA  = 2'b01;
    localparam logic [1:0] OP_BAIXO    = 2'b10;
    localparam logic [1:0] OP_ESQUERDA = 2'b11;

endpackage

// File: rtl/uc_dispara_tiro.sv
// Control unit for shot spawning: scans for a free slot, writes the shot,
// then holds off new requests for the cooldown period.
module uc_dispara_tiro
    import dispara_tiro_pkg::*;
(
    input  logic    clock_i,
    input  logic    reset_i,
    input  logic    disparar_i,
    input  logic    loaded_i,
    input  logic    slot_ultimo_i,
    input  logic    cd_zero_i,
    output estado_t estado_o,
    output logic    latch_o,
    output logic    inc_slot_o,
    output logic    load_cd_o,
    output logic    dec_cd_o,
    output logic    we_o,
    output logic    ocupado_o,
    output logic    concluido_o,
    output logic    sem_espaco_o
);

    estado_t estado_q;
    logic    we_q;
    logic    ocupado_q;
    logic    concluido_q;
    logic    sem_espaco_q;

    // External outputs are registered alongside the state, so each is set on
    // the transition into the state where it must be visible.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            // NOTE: non-blocking assignments in clocked blocks, so every register samples pre-edge values.
            estado_q     <= INICIAL;
            we_q         <= 1'b0;
            ocupado_q    <= 1'b0;
            concluido_q  <= 1'b0;
            sem_espaco_q <= 1'b0;
        end else begin
            we_q         <= 1'b0;
            concluido_q  <= 1'b0;
            sem_espaco_q <= 1'b0;
            ocupado_q    <= 1'b1;
            case (estado_q)
                INICIAL: begin
                    estado_q  <= ESPERA;
                    ocupado_q <= 1'b0;
                end
                ESPERA: begin
                    if (disparar_i) estado_q <= LE_SLOT;
                    else            ocupado_q <= 1'b0;
                end
                LE_SLOT: estado_q <= AGUARDA;
                AGUARDA: estado_q <= TESTA;
                TESTA: begin
                    if (!loaded_i) begin
                        estado_q <= ESCREVE;
                        we_q     <= 1'b1;
                    end else if (slot_ultimo_i) begin
                        estado_q     <= SEM_ESPACO;
                        sem_espaco_q <= 1'b1;
                    end else begin
                        estado_q <= PROXIMO;
                    end
                end
                PROXIMO: estado_q <= LE_SLOT;
                ESCREVE: begin
                    estado_q    <= CONCLUIDO;
                    concluido_q <= 1'b1;
                end
                CONCLUIDO: estado_q <= COOLDOWN;
                COOLDOWN: begin
                    if (cd_zero_i) begin
                        estado_q  <= ESPERA;
                        ocupado_q <= 1'b0;
                    end
                end
                SEM_ESPACO: begin
                    estado_q  <= ESPERA;
                    ocupado_q <= 1'b0;
                end
                default: estado_q <= INICIAL;
            endcase
        end
    end

    assign latch_o      = (estado_q == ESPERA) && disparar_i;
    assign inc_slot_o   = (estado_q == PROXIMO);
    assign load_cd_o    = (estado_q == CONCLUIDO);
    assign dec_cd_o     = (estado_q == COOLDOWN);
    assign estado_o     = estado_q;
    assign we_o         = we_q;
    assign ocupado_o    = ocupado_q;
    assign concluido_o  = concluido_q;
    assign sem_espaco_o = sem_espaco_q;

endmodule

// File: rtl/dispara_tiro.sv
// Shot-spawn controller top: datapath (slot counter, cooldown counter,
// latched ship state) plus the uc_dispara_tiro control unit.
module dispara_tiro
    import dispara_tiro_pkg::*;
#(
    parameter int N_TIROS         = 4,
    parameter int ADDR_W          = 2,
    parameter int COORD_W         = 5,
    parameter int COOLDOWN_CICLOS = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               disparar,
    input  logic [COORD_W-1:0] nave_coor_x,
    input  logic [COORD_W-1:0] nave_coor_y,
    input  logic [1:0]         nave_direcao,
    input  logic               mem_loaded_tiro,
    output logic [ADDR_W-1:0]  mem_addr_tiro,
    output logic               mem_we_tiro,
    output logic [COORD_W-1:0] mem_wdata_x,
    output logic [COORD_W-1:0] mem_wdata_y,
    output logic [1:0]         mem_wdata_opcode,
    output logic               mem_wdata_loaded,
    output logic               ocupado,
    output logic               disparo_concluido,
    output logic               sem_espaco,
    output logic [4:0]         db_estado
);

    localparam int CD_W = $clog2(COOLDOWN_CICLOS + 1);

    logic [ADDR_W-1:0]  slot_q, slot_d;
    logic [CD_W-1:0]    cd_q, cd_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [1:0]         op_q, op_d;

    estado_t estado;
    logic    latch_en, inc_slot, load_cd, dec_cd, we;
    logic    slot_ultimo, cd_zero;

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path leaves it unassigned and no latch is inferred.
        slot_d = slot_q;
        cd_d   = cd_q;
        x_d    = x_q;
        y_d    = y_q;
        op_d   = op_q;
        if (latch_en) begin
            x_d    = nave_coor_x;
            y_d    = nave_coor_y;
            op_d   = nave_direcao;
            slot_d = '0;
        end
        if (inc_slot) slot_d = slot_q + ADDR_W'(1);
        if (load_cd) cd_d = CD_W'(COOLDOWN_CICLOS - 1);
        else if (dec_cd && cd_q != '0) cd_d = cd_q - CD_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_q <= '0;
            cd_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            op_q   <= '0;
        end else begin
            slot_q <= slot_d;
            cd_q   <= cd_d;
            x_q    <= x_d;
            y_q    <= y_d;
            op_q   <= op_d;
        end
    end

    assign slot_ultimo = (slot_q == ADDR_W'(N_TIROS - 1));
    assign cd_zero     = (cd_q == '0);

    uc_dispara_tiro u_uc (
        .clock_i       (clock),
        .reset_i       (reset),
        .disparar_i    (disparar),
        .loaded_i      (mem_loaded_tiro),
        .slot_ultimo_i (slot_ultimo),
        .cd_zero_i     (cd_zero),
        .estado_o      (estado),
        .latch_o       (latch_en),
        .inc_slot_o    (inc_slot),
        .load_cd_o     (load_cd),
        .dec_cd_o      (dec_cd),
        .we_o          (we),
        .ocupado_o     (ocupado),
        .concluido_o   (disparo_concluido),
        .sem_espaco_o  (sem_espaco)
    );

    // The slot counter only moves on accept and in PROXIMO, so the address
    // naturally holds outside the read/test/write window.
    assign mem_addr_tiro    = slot_q;
    assign mem_we_tiro      = we;
    assign mem_wdata_x      = x_q;
    assign mem_wdata_y      = y_q;
    assign mem_wdata_opcode = op_q;
    assign mem_wdata_loaded = we;
    assign db_estado        = estado;

endmodule

// File: tb/tb_dispara_tiro.sv
// Directed bench for dispara_tiro with a 4-slot registered-read shot memory model.
module tb_dispara_tiro;
    import dispara_tiro_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       disparar;
    logic [4:0] nave_coor_x, nave_coor_y;
    logic [1:0] nave_direcao;
    logic       mem_loaded_tiro;
    logic [1:0] mem_addr_tiro;
    logic       mem_we_tiro;
    logic [4:0] mem_wdata_x, mem_wdata_y;
    logic [1:0] mem_wdata_opcode;
    logic       mem_wdata_loaded;
    logic       ocupado, disparo_concluido, sem_espaco;
    logic [4:0] db_estado;

    int checks = 0;
    int errors = 0;

    dispara_tiro dut (
        .clock             (clock),
        .reset             (reset),
        .disparar          (disparar),
        .nave_coor_x       (nave_coor_x),
        .nave_coor_y       (nave_coor_y),
        .nave_direcao      (nave_direcao),
        .mem_loaded_tiro   (mem_loaded_tiro),
        .mem_addr_tiro     (mem_addr_tiro),
        .mem_we_tiro       (mem_we_tiro),
        .mem_wdata_x       (mem_wdata_x),
        .mem_wdata_y       (mem_wdata_y),
        .mem_wdata_opcode  (mem_wdata_opcode),
        .mem_wdata_loaded  (mem_wdata_loaded),
        .ocupado           (ocupado),
        .disparo_concluido (disparo_concluido),
        .sem_espaco        (sem_espaco),
        .db_estado         (db_estado)
    );

    always #5 clock = ~clock;

    // Shot memory: loaded bits only, registered read.
    logic [3:0] loaded_vec = 4'b0000;
    logic [3:0] preset_val = 4'b0000;
    logic       preset_en  = 1'b0;

    always @(posedge clock) begin
        if (preset_en)        loaded_vec <= preset_val;
        else if (mem_we_tiro) loaded_vec[mem_addr_tiro] <= mem_wdata_loaded;
        mem_loaded_tiro <= loaded_vec[mem_addr_tiro];
    end

    // Observations collected by fire(), relative to the accept cycle (i=0).
    int         obs_nwe, obs_twe, obs_twe2, obs_tconc, obs_nconc;
    int         obs_tsem, obs_nsem, obs_tidle, obs_cd;
    logic       obs_ocup_ok;
    logic [1:0] obs_addr, obs_addr2, obs_op;
    logic [4:0] obs_x, obs_y;
    logic       obs_ld;

    task automatic preset_mem(input logic [3:0] v);
        preset_val = v;
        preset_en  = 1'b1;
        @(negedge clock);
        preset_en  = 1'b0;
        @(negedge clock);
    endtask

    // Called at a negedge with the DUT in ESPERA.
    task automatic fire(input int hold, input int chg_at, input logic [4:0] chg_x, input int budget);
        obs_nwe = 0; obs_twe = -1; obs_twe2 = -1; obs_tconc = -1; obs_nconc = 0;
        obs_tsem = -1; obs_nsem = 0; obs_tidle = -1; obs_cd = 0; obs_ocup_ok = 1'b1;
        obs_addr = 2'bxx; obs_addr2 = 2'bxx; obs_op = 2'bxx;
        obs_x = 5'bx; obs_y = 5'bx; obs_ld = 1'bx;
        disparar = 1'b1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clock);
            if (i == hold) disparar = 1'b0;
            if (i == chg_at) nave_coor_x = chg_x;
            if (mem_we_tiro) begin
                obs_nwe++;
                if (obs_nwe == 1) begin
                    obs_twe = i; obs_addr = mem_addr_tiro; obs_x = mem_wdata_x;
                    obs_y = mem_wdata_y; obs_op = mem_wdata_opcode; obs_ld = mem_wdata_loaded;
                end else begin
                    obs_twe2 = i; obs_addr2 = mem_addr_tiro;
                end
            end
            if (disparo_concluido) begin obs_nconc++; obs_tconc = i; end
            if (sem_espaco) begin obs_nsem++; obs_tsem = i; end
            if (db_estado == 5'd9 && obs_nwe == 1) obs_cd++;
            if (db_estado == 5'd1 && !disparar) begin obs_tidle = i; break; end
            if (!ocupado) obs_ocup_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; disparar = 1'b0;
        nave_coor_x = 5'd0; nave_coor_y = 5'd0; nave_direcao = 2'b00;
        repeat (2) @(negedge clock);
        checks++; if (db_estado !== 5'd0) begin errors++; $display("FAIL reset_estado got %0d want 0", db_estado); end
        checks++;
        if ({mem_we_tiro, ocupado, disparo_concluido, sem_espaco, mem_wdata_loaded} !== 5'b0 ||
            {mem_addr_tiro, mem_wdata_x, mem_wdata_y, mem_wdata_opcode} !== 14'b0) begin
            errors++; $display("FAIL reset_outputs got we=%b oc=%b cc=%b se=%b addr=%0d x=%0d y=%0d op=%0d want all 0",
                mem_we_tiro, ocupado, disparo_concluido, sem_espaco, mem_addr_tiro, mem_wdata_x, mem_wdata_y, mem_wdata_opcode);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++; if (db_estado !== 5'd1 || ocupado !== 1'b0) begin
            errors++; $display("FAIL reset_to_espera got estado=%0d ocupado=%b want 1 0", db_estado, ocupado);
        end
    endtask

    task automatic test_single_shot;
        preset_mem(4'b0000);
        nave_coor_x = 5'd10; nave_coor_y = 5'd7; nave_direcao = OP_DIREITA;
        fire(1, 0, 5'd0, 40);
        checks++; if (obs_nwe !== 1) begin errors++; $display("FAIL t1_nwe got %0d want 1", obs_nwe); end
        checks++; if (obs_twe !== 4) begin errors++; $display("FAIL t1_write_lat got %0d want 4", obs_twe); end
        checks++; if (obs_addr !== 2'd0) begin errors++; $display("FAIL t1_addr got %0d want 0", obs_addr); end
        checks++; if ({obs_x, obs_y, obs_op, obs_ld} !== {5'd10, 5'd7, 2'b01, 1'b1}) begin
            errors++; $display("FAIL t1_wdata got x=%0d y=%0d op=%0d ld=%b want 10 7 1 1", obs_x, obs_y, obs_op, obs_ld);
        end
        checks++; if (obs_tconc !== 5 || obs_nconc !== 1) begin
            errors++; $display("FAIL t1_concluido got t=%0d n=%0d want 5 1", obs_tconc, obs_nconc);
        end
        checks++; if (obs_ocup_ok !== 1'b1) begin errors++; $display("FAIL t1_ocupado got drop want held high"); end
        checks++; if (obs_tidle !== 14) begin errors++; $display("FAIL t1_idle got %0d want 14", obs_tidle); end
    endtask

    task automatic test_skip_loaded;
        preset_mem(4'b0011);
        nave_coor_x = 5'd3; nave_coor_y = 5'd30; nave_direcao = OP_BAIXO;
        fire(1, 0, 5'd0, 40);
        checks++; if (obs_nwe !== 1) begin errors++; $display("FAIL t2_nwe got %0d want 1", obs_nwe); end
        checks++; if (obs_addr !== 2'd2) begin errors++; $display("FAIL t2_addr got %0d want 2", obs_addr); end
        checks++; if (obs_twe !== 12) begin errors++; $display("FAIL t2_write_lat got %0d want 12", obs_twe); end
        checks++; if (obs_tconc !== 13) begin errors++; $display("FAIL t2_concluido got %0d want 13", obs_tconc); end
        checks++; if ({obs_x, obs_y, obs_op} !== {5'd3, 5'd30, 2'b10}) begin
            errors++; $display("FAIL t2_wdata got x=%0d y=%0d op=%0d want 3 30 2", obs_x, obs_y, obs_op);
        end
    endtask

    task automatic test_full;
        preset_mem(4'b1111);
        nave_coor_x = 5'd1; nave_coor_y = 5'd1; nave_direcao = OP_CIMA;
        fire(1, 0, 5'd0, 40);
        checks++; if (obs_nwe !== 0) begin errors++; $display("FAIL t3_nwe got %0d want 0", obs_nwe); end
        checks++; if (obs_nsem !== 1 || obs_tsem !== 16) begin
            errors++; $display("FAIL t3_sem_espaco got n=%0d t=%0d want 1 16", obs_nsem, obs_tsem);
        end
        checks++; if (obs_nconc !== 0) begin errors++; $display("FAIL t3_concluido got %0d want 0", obs_nconc); end
        checks++; if (obs_tidle !== 17) begin errors++; $display("FAIL t3_idle got %0d want 17", obs_tidle); end
    endtask

    task automatic test_back_to_back;
        preset_mem(4'b0000);
        nave_coor_x = 5'd1; nave_coor_y = 5'd2; nave_direcao = OP_ESQUERDA;
        fire(23, 0, 5'd0, 60);
        checks++; if (obs_nwe !== 2) begin errors++; $display("FAIL t4_nwe got %0d want 2", obs_nwe); end
        checks++; if (obs_twe !== 4 || obs_addr !== 2'd0) begin
            errors++; $display("FAIL t4_first got t=%0d addr=%0d want 4 0", obs_twe, obs_addr);
        end
        checks++; if (obs_twe2 !== 22 || obs_addr2 !== 2'd1) begin
            errors++; $display("FAIL t4_second got t=%0d addr=%0d want 22 1", obs_twe2, obs_addr2);
        end
        checks++; if (obs_cd !== 8) begin errors++; $display("FAIL t4_cooldown got %0d want 8", obs_cd); end
        checks++; if (obs_tidle !== 32) begin errors++; $display("FAIL t4_idle got %0d want 32", obs_tidle); end
    endtask

    task automatic test_reset_mid_scan;
        int nwe;
        preset_mem(4'b0000);
        nave_coor_x = 5'd9; nave_coor_y = 5'd9; nave_direcao = OP_BAIXO;
        disparar = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            disparar = 1'b0;
        end
        checks++; if (db_estado !== 5'd4) begin errors++; $display("FAIL t5_testa got %0d want 4", db_estado); end
        reset = 1'b1;
        @(negedge clock);
        checks++; if (db_estado !== 5'd0) begin errors++; $display("FAIL t5_estado got %0d want 0", db_estado); end
        checks++;
        if ({mem_we_tiro, ocupado, disparo_concluido, sem_espaco, mem_wdata_loaded} !== 5'b0 ||
            {mem_addr_tiro, mem_wdata_x, mem_wdata_y, mem_wdata_opcode} !== 14'b0) begin
            errors++; $display("FAIL t5_outputs got we=%b oc=%b x=%0d y=%0d op=%0d want all 0",
                mem_we_tiro, ocupado, mem_wdata_x, mem_wdata_y, mem_wdata_opcode);
        end
        reset = 1'b0;
        nwe = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (mem_we_tiro) nwe++;
        end
        checks++; if (nwe !== 0 || loaded_vec !== 4'b0000) begin
            errors++; $display("FAIL t5_no_write got writes=%0d mem=%b want 0 0000", nwe, loaded_vec);
        end
        checks++; if (db_estado !== 5'd1) begin errors++; $display("FAIL t5_espera got %0d want 1", db_estado); end
    endtask

    task automatic test_input_change;
        preset_mem(4'b0000);
        nave_coor_x = 5'd10; nave_coor_y = 5'd5; nave_direcao = OP_CIMA;
        fire(1, 1, 5'd20, 40);
        checks++; if (obs_nwe !== 1 || obs_addr !== 2'd0) begin
            errors++; $display("FAIL t6_write got n=%0d addr=%0d want 1 0", obs_nwe, obs_addr);
        end
        checks++; if ({obs_x, obs_y, obs_op} !== {5'd10, 5'd5, 2'b00}) begin
            errors++; $display("FAIL t6_latched got x=%0d y=%0d op=%0d want 10 5 0", obs_x, obs_y, obs_op);
        end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_skip_loaded();
        test_full();
        test_back_to_back();
        test_reset_mid_scan();
        test_input_change();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no completion want finish");
        $fatal(1);
    end

endmodule
